// File: rtl/upcounter_pkg.sv
// Shared definitions for the 8-bit up/rotate counter and its op decoder.
//   CNT_DATA_W  : counter data width
//   CNT_RESET   : counter value after reset
//   op_t        : counter control bit encoding
//   dec_state_t : decoder lock state
package upcounter_pkg;

    localparam int CNT_DATA_W = 8;
    localparam logic [CNT_DATA_W-1:0] CNT_RESET = 8'h00;

    typedef enum logic {
        OP_INC = 1'b0,
        OP_ROL = 1'b1
    } op_t;

    typedef enum logic {
        TRACK = 1'b0,
        HUNT  = 1'b1
    } dec_state_t;

endpackage

// File: rtl/upcounter_op_decoder_if.sv
// Bus between the counter sample stream and the op decoder.
//   in_valid/in_data : one counter output sample per asserted cycle
//   out_*            : registered decode result, one-cycle pulse
//   locked           : decoder is tracking
//   err_count        : saturating mismatch total
//
// Handshake: valid-only stream. A sample is consumed on every rising edge
// where in_valid is high; there is no ready, so the sink must keep up at one
// sample per cycle. out_valid qualifies out_op/out_ambig/out_err for exactly
// that cycle; locked and err_count are level signals, always meaningful.
interface upcounter_op_decoder_if
    import upcounter_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic                  in_valid;
    logic [CNT_DATA_W-1:0] in_data;
    logic                  out_valid;
    logic                  out_op;
    logic                  out_ambig;
    logic                  out_err;
    logic                  locked;
    logic [CNT_W-1:0]      err_count;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_op, out_ambig, out_err, locked, err_count
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_op, out_ambig, out_err, locked, err_count
    );

endinterface

// File: rtl/upcounter_step_predict.sv
// Combinational next-value predictor for the up/rotate counter.
//   prev_i : current counter value
//   inc_o  : value after an increment step (wraps mod 256)
//   rol_o  : value after a rotate-left step
module upcounter_step_predict
    import upcounter_pkg::*;
(
    input  logic [CNT_DATA_W-1:0] prev_i,
    output logic [CNT_DATA_W-1:0] inc_o,
    output logic [CNT_DATA_W-1:0] rol_o
);

    assign inc_o = prev_i + CNT_DATA_W'(1);
    assign rol_o = {prev_i[CNT_DATA_W-2:0], prev_i[CNT_DATA_W-1]};

endmodule

// File: rtl/upcounter_op_decoder.sv
// Recovers the control bit (increment / rotate-left) behind each step of the
// up/rotate counter from its output stream, flags ambiguous and impossible
// steps, counts mismatches and reseeds after ERR_LIMIT consecutive misses.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : sample stream in, decode results out (slave modport)
//   dbg_state_o : current lock state
module upcounter_op_decoder
    import upcounter_pkg::*;
#(
    parameter int ERR_LIMIT = 3,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    upcounter_op_decoder_if.slave  bus,
    output dec_state_t             dbg_state_o
);

    localparam int MISS_W = $clog2(ERR_LIMIT + 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(ERR_LIMIT);

    dec_state_t            state_q, state_d;
    logic [CNT_DATA_W-1:0] prev_q, prev_d;
    logic [MISS_W-1:0]     miss_q, miss_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  vld_q, vld_d;
    op_t                   op_q, op_d;
    logic                  amb_q, amb_d;
    logic                  err_q, err_d;

    logic [CNT_DATA_W-1:0] inc_pred;
    logic [CNT_DATA_W-1:0] rol_pred;
    logic                  hit_inc;
    logic                  hit_rol;

    upcounter_step_predict u_predict (
        .prev_i (prev_q),
        .inc_o  (inc_pred),
        .rol_o  (rol_pred)
    );

    assign hit_inc = (bus.in_data == inc_pred);
    assign hit_rol = (bus.in_data == rol_pred);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        miss_d  = miss_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;
        op_d    = OP_INC;
        amb_d   = 1'b0;
        err_d   = 1'b0;

        if (bus.in_valid) begin
            // Always follow the observed value so one bad sample does not
            // poison the prediction for the next one.
            prev_d = bus.in_data;
            case (state_q)
                TRACK: begin
                    vld_d = 1'b1;
                    if (hit_inc && hit_rol) begin
                        // Only possible from 0x01: report increment, flag it.
                        amb_d  = 1'b1;
                        miss_d = '0;
                    end else if (hit_inc) begin
                        miss_d = '0;
                    end else if (hit_rol) begin
                        op_d   = OP_ROL;
                        miss_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if ((miss_q + MISS_W'(1)) == MISS_LIMIT) begin
                            state_d = HUNT;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                HUNT: begin
                    // Seed sample: no decode, just resume tracking from it.
                    state_d = TRACK;
                end
                default: state_d = TRACK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TRACK;
            prev_q  <= CNT_RESET;
            miss_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            op_q    <= OP_INC;
            amb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            miss_q  <= miss_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            op_q    <= op_d;
            amb_q   <= amb_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_op    = op_q;
    assign bus.out_ambig = amb_q;
    assign bus.out_err   = err_q;
    assign bus.locked    = (state_q == TRACK);
    assign bus.err_count = cnt_q;
    assign dbg_state_o   = state_q;

endmodule
